viterbi_frame_ctrl: RTL

Frame sequencer between the TinyTapeout pin interface and the Viterbi decoder datapath (ACS/path-metric unit, traceback unit, decoded-bit RAM). Accepts packed symbol bytes from the host, unpacks them into the symbol buffer, steps the ACS unit once per symbol, launches traceback, then packs decoded bits into output bytes with a valid/ack handshake. Owns busy/frame_done status and overflow detection.

---
 rtl/viterbi_frame_ctrl_if.sv | 27 ++
 rtl/viterbi_frame_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_frame_ctrl_if.sv
// Host-side byte handshake and status bundle for viterbi_frame_ctrl.
// master = host/pin side, slave = frame controller.
interface viterbi_frame_ctrl_if #(
  parameter int AW = 6
) ();
  logic          byte_in_stb;
  logic [7:0]    byte_in;
  logic          start_stb;
  logic          out_ack;
  logic [AW:0]   frame_bits;
  logic          byte_in_ready;
  logic          byte_out_valid;
  logic [7:0]    byte_out;
  logic          busy;
  logic          frame_done;
  logic          overflow;

  modport master (
    output byte_in_stb, byte_in, start_stb, out_ack, frame_bits,
    input  byte_in_ready, byte_out_valid, byte_out, busy, frame_done, overflow
  );

  modport slave (
    input  byte_in_stb, byte_in, start_stb, out_ack, frame_bits,
    output byte_in_ready, byte_out_valid, byte_out, busy, frame_done, overflow
  );
endinterface

// File: rtl/viterbi_frame_ctrl.sv
// Viterbi frame sequencer: symbol unpack, ACS stepping, traceback launch, output bit packing.
// Optional macro VIT_CYCLE_COUNT_EN adds a saturating busy-cycle counter output.
module viterbi_frame_ctrl #(
  parameter int MAX_SYMS = 64,
  parameter int AW       = 6,
  parameter int M        = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  viterbi_frame_ctrl_if.slave  host,
  output logic                 sym_we,
  output logic [AW-1:0]        sym_waddr,
  output logic [1:0]           sym_wdata,
  output logic                 step_go,
  output logic [AW-1:0]        step_idx,
  input  logic                 step_done,
  output logic                 tb_go,
  output logic [AW:0]          tb_len,
  input  logic                 tb_done,
`ifdef VIT_CYCLE_COUNT_EN
  output logic [15:0]          cycle_count,
`endif
  output logic [AW-1:0]        bit_raddr,
  input  logic                 bit_rdata
);

  typedef enum logic [3:0] {
    S_IDLE, S_UNPACK, S_STEP_ISSUE, S_STEP_WAIT, S_TB_ISSUE,
    S_TB_WAIT, S_PACK, S_OUT, S_DONE
  } state_t;

  localparam logic [AW+1:0] MAX_W   = (AW+2)'(MAX_SYMS);
  localparam logic [AW+1:0] FOUR_W  = (AW+2)'(4);
  localparam logic [AW:0]   M_W     = (AW+1)'(M);
  localparam logic [AW:0]   ONE_W   = (AW+1)'(1);
  localparam logic [AW:0]   EIGHT_W = (AW+1)'(8);

  state_t      state_q, state_d;
  logic [AW:0] sym_count_q, sym_count_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [1:0]  unpack_cnt_q, unpack_cnt_d;
  logic [AW:0] nbits_q, nbits_d;
  logic [AW:0] step_idx_q, step_idx_d;
  logic [AW:0] byte_base_q, byte_base_d;
  logic [3:0]  pack_cnt_q, pack_cnt_d;
  logic [7:0]  byte_out_q, byte_out_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;
  logic        overflow_q, overflow_d;

  logic [AW:0] eff_count;
  logic [AW:0] start_nbits;
  logic [AW:0] cap_idx;

  // After a finished frame the next byte starts a fresh buffer, so its room check sees zero.
  assign eff_count   = frame_done_q ? '0 : sym_count_q;
  assign start_nbits = (host.frame_bits != '0) ? host.frame_bits : (sym_count_q - M_W);
  // Bit arriving now was addressed one cycle earlier (1-cycle RAM latency).
  assign cap_idx     = byte_base_q + (AW+1)'(pack_cnt_q) - ONE_W;

  // NOTE: every _d gets its hold value first so no path through the case can infer a latch.
  always_comb begin
    state_d      = state_q;
    sym_count_d  = sym_count_q;
    shreg_d      = shreg_q;
    unpack_cnt_d = unpack_cnt_q;
    nbits_d      = nbits_q;
    step_idx_d   = step_idx_q;
    byte_base_d  = byte_base_q;
    pack_cnt_d   = pack_cnt_q;
    byte_out_d   = byte_out_q;
    busy_d       = busy_q;
    frame_done_d = frame_done_q;
    overflow_d   = overflow_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (host.byte_in_stb) begin
          if (frame_done_q) begin
            frame_done_d = 1'b0;
            overflow_d   = 1'b0;
            sym_count_d  = '0;
          end
          if (({1'b0, eff_count} + FOUR_W) <= MAX_W) begin
            shreg_d      = host.byte_in;
            unpack_cnt_d = 2'd0;
            state_d      = S_UNPACK;
          end else begin
            overflow_d = 1'b1;
          end
        end else if (host.start_stb) begin
          if ((sym_count_q <= M_W) || (start_nbits == '0) || (start_nbits > sym_count_q)) begin
            frame_done_d = 1'b1;
            state_d      = S_DONE;
          end else begin
            nbits_d      = start_nbits;
            step_idx_d   = '0;
            busy_d       = 1'b1;
            frame_done_d = 1'b0;
            state_d      = S_STEP_ISSUE;
          end
        end
      end

      S_UNPACK: begin
        sym_count_d  = sym_count_q + ONE_W;
        shreg_d      = {2'b00, shreg_q[7:2]};
        unpack_cnt_d = unpack_cnt_q + 2'd1;
        if (unpack_cnt_q == 2'd3) state_d = S_IDLE;
      end

      S_STEP_ISSUE: state_d = S_STEP_WAIT;

      S_STEP_WAIT: begin
        if (step_done) begin
          step_idx_d = step_idx_q + ONE_W;
          state_d    = ((step_idx_q + ONE_W) == sym_count_q) ? S_TB_ISSUE : S_STEP_ISSUE;
        end
      end

      S_TB_ISSUE: state_d = S_TB_WAIT;

      S_TB_WAIT: begin
        if (tb_done) begin
          byte_base_d = '0;
          pack_cnt_d  = 4'd0;
          state_d     = S_PACK;
        end
      end

      S_PACK: begin
        pack_cnt_d = pack_cnt_q + 4'd1;
        if (pack_cnt_q != 4'd0)
          byte_out_d = {bit_rdata & (cap_idx < nbits_q), byte_out_q[7:1]};
        if (pack_cnt_q == 4'd8) begin
          pack_cnt_d = 4'd0;
          busy_d     = 1'b0;
          state_d    = S_OUT;
        end
      end

      S_OUT: begin
        if (host.out_ack) begin
          byte_base_d = byte_base_q + EIGHT_W;
          if ((byte_base_q + EIGHT_W) >= nbits_q) begin
            frame_done_d = 1'b1;
            state_d      = S_DONE;
          end else begin
            pack_cnt_d = 4'd0;
            state_d    = S_PACK;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sym_count_q  <= '0;
      shreg_q      <= '0;
      unpack_cnt_q <= '0;
      nbits_q      <= '0;
      step_idx_q   <= '0;
      byte_base_q  <= '0;
      pack_cnt_q   <= '0;
      byte_out_q   <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sym_count_q  <= sym_count_d;
      shreg_q      <= shreg_d;
      unpack_cnt_q <= unpack_cnt_d;
      nbits_q      <= nbits_d;
      step_idx_q   <= step_idx_d;
      byte_base_q  <= byte_base_d;
      pack_cnt_q   <= pack_cnt_d;
      byte_out_q   <= byte_out_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

`ifdef VIT_CYCLE_COUNT_EN
  logic start_accept;
  assign start_accept = ((state_q == S_IDLE) || (state_q == S_DONE)) &&
                        !host.byte_in_stb && host.start_stb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  cycle_count <= '0;
    else if (start_accept)                       cycle_count <= '0;
    else if (busy_q && (cycle_count != 16'hFFFF)) cycle_count <= cycle_count + 16'd1;
  end
`endif

  assign host.byte_in_ready  = (state_q == S_IDLE) || (state_q == S_DONE);
  assign host.byte_out_valid = (state_q == S_OUT);
  assign host.byte_out       = byte_out_q;
  assign host.busy           = busy_q;
  assign host.frame_done     = frame_done_q;
  assign host.overflow       = overflow_q;

  assign sym_we    = (state_q == S_UNPACK);
  assign sym_waddr = sym_count_q[AW-1:0];
  assign sym_wdata = shreg_q[1:0];
  assign step_go   = (state_q == S_STEP_ISSUE);
  assign step_idx  = step_idx_q[AW-1:0];
  assign tb_go     = (state_q == S_TB_ISSUE);
  assign tb_len    = sym_count_q;
  assign bit_raddr = byte_base_q[AW-1:0] + AW'(pack_cnt_q);

endmodule
